// File: rtl/video_timer_pg.sv
`default_nettype none
// ============================================================================
// Module   : video_timer_pg
// Purpose  : Parametrised video timing generator. Pixel/line counters drive
//            registered hsync, vsync, data-enable and start-of-line/frame
//            strobes. A double-buffered config set lets a new mode be staged
//            at any time and swapped in only at a frame boundary.
// Revision : 1.0 - initial release
// ============================================================================
module video_timer_pg #(
  parameter int PIX_W  = 12,
  parameter int LINE_W = 10
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              enable,
  input  logic              reset_timer,
  input  logic              cfg_load,
  input  logic [PIX_W-1:0]  cfg_ticks_per_line,
  input  logic [LINE_W-1:0] cfg_lines_per_frame,
  input  logic [PIX_W-1:0]  cfg_hs_start,
  input  logic [PIX_W-1:0]  cfg_hs_stop,
  input  logic [PIX_W-1:0]  cfg_vs_pix_start,
  input  logic [PIX_W-1:0]  cfg_vs_pix_stop,
  input  logic [LINE_W-1:0] cfg_vs_line_start,
  input  logic [LINE_W-1:0] cfg_vs_line_stop,
  input  logic [PIX_W-1:0]  cfg_de_pix_start,
  input  logic [PIX_W-1:0]  cfg_de_pix_stop,
  input  logic [LINE_W-1:0] cfg_de_line_start,
  input  logic [LINE_W-1:0] cfg_de_line_stop,
  input  logic [LINE_W-1:0] cfg_starting_line,
  input  logic              cfg_active_high,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              sol,
  output logic              sof,
  output logic [PIX_W-1:0]  pix_counter,
  output logic [LINE_W-1:0] line_counter,
  output logic              cfg_pending,
  output logic              running
);

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0]  ticks;
    logic [LINE_W-1:0] lines;
    logic [PIX_W-1:0]  hs_start;
    logic [PIX_W-1:0]  hs_stop;
    logic [PIX_W-1:0]  vs_pix_start;
    logic [PIX_W-1:0]  vs_pix_stop;
    logic [LINE_W-1:0] vs_line_start;
    logic [LINE_W-1:0] vs_line_stop;
    logic [PIX_W-1:0]  de_pix_start;
    logic [PIX_W-1:0]  de_pix_stop;
    logic [LINE_W-1:0] de_line_start;
    logic [LINE_W-1:0] de_line_stop;
    logic [LINE_W-1:0] starting_line;
    logic              active_high;
  } cfg_t;

  state_t            state_q;
  cfg_t              work_q;
  cfg_t              shad_q;
  cfg_t              cfg_in;
  logic [PIX_W-1:0]  pix_q;
  logic [PIX_W-1:0]  pix_d;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;
  logic              vs_act_q;
  logic              vs_act_d;
  logic              hsync_q, vsync_q, de_q, sol_q, sof_q;
  logic              pend_q, run_q;
  logic              line_end, frame_wrap, hs_hit, de_hit;
  logic              restart_ah;

  // Gather the cfg_* inputs into one record for shadow/working captures
  always_comb begin
    cfg_in               = '0;
    cfg_in.ticks         = cfg_ticks_per_line;
    cfg_in.lines         = cfg_lines_per_frame;
    cfg_in.hs_start      = cfg_hs_start;
    cfg_in.hs_stop       = cfg_hs_stop;
    cfg_in.vs_pix_start  = cfg_vs_pix_start;
    cfg_in.vs_pix_stop   = cfg_vs_pix_stop;
    cfg_in.vs_line_start = cfg_vs_line_start;
    cfg_in.vs_line_stop  = cfg_vs_line_stop;
    cfg_in.de_pix_start  = cfg_de_pix_start;
    cfg_in.de_pix_stop   = cfg_de_pix_stop;
    cfg_in.de_line_start = cfg_de_line_start;
    cfg_in.de_line_stop  = cfg_de_line_stop;
    cfg_in.starting_line = cfg_starting_line;
    cfg_in.active_high   = cfg_active_high;
  end

  // Next counter values, window decodes for the current counter position
  always_comb begin
    line_end   = (pix_q == work_q.ticks);
    frame_wrap = enable && line_end && (line_q == work_q.lines);
    pix_d      = line_end ? '0 : pix_q + PIX_W'(1);
    line_d     = line_q;
    if (line_end) begin
      line_d = (line_q == work_q.lines) ? '0 : line_q + LINE_W'(1);
    end

    hs_hit = 1'b0;
    if (work_q.hs_start < work_q.hs_stop) begin
      hs_hit = (pix_q >= work_q.hs_start) && (pix_q < work_q.hs_stop);
    end else if (work_q.hs_start > work_q.hs_stop) begin
      hs_hit = (pix_q >= work_q.hs_start) || (pix_q < work_q.hs_stop);
    end

    // Clear is checked first so it wins when both points coincide
    vs_act_d = vs_act_q;
    if ((line_q == work_q.vs_line_stop) && (pix_q == work_q.vs_pix_stop)) begin
      vs_act_d = 1'b0;
    end else if ((line_q == work_q.vs_line_start) && (pix_q == work_q.vs_pix_start)) begin
      vs_act_d = 1'b1;
    end

    de_hit = (pix_q >= work_q.de_pix_start) && (pix_q < work_q.de_pix_stop) &&
             (line_q >= work_q.de_line_start) && (line_q < work_q.de_line_stop);

    // On a restart from PEND the shadow becomes the working set immediately
    restart_ah = (state_q == PEND) ? shad_q.active_high : work_q.active_high;
  end

  // Control FSM, counters, config sets and registered outputs
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= UNCFG;
      work_q   <= '0;
      shad_q   <= '0;
      pix_q    <= '0;
      line_q   <= '0;
      vs_act_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      sol_q    <= 1'b0;
      sof_q    <= 1'b0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      case (state_q)
        UNCFG: begin
          if (cfg_load) begin
            work_q  <= cfg_in;
            pix_q   <= '0;
            line_q  <= cfg_starting_line;
            state_q <= RUN;
            run_q   <= 1'b1;
          end
        end
        default: begin
          if (reset_timer) begin
            if (state_q == PEND) begin
              work_q <= shad_q;
              line_q <= shad_q.starting_line;
            end else begin
              line_q <= work_q.starting_line;
            end
            pix_q    <= '0;
            vs_act_q <= 1'b0;
            hsync_q  <= ~restart_ah;
            vsync_q  <= ~restart_ah;
            de_q     <= 1'b0;
            sol_q    <= 1'b0;
            sof_q    <= 1'b0;
            state_q  <= RUN;
            pend_q   <= 1'b0;
          end else begin
            if (enable) begin
              pix_q    <= pix_d;
              line_q   <= line_d;
              vs_act_q <= vs_act_d;
              hsync_q  <= hs_hit ? work_q.active_high : ~work_q.active_high;
              vsync_q  <= vs_act_d ? work_q.active_high : ~work_q.active_high;
              de_q     <= de_hit;
              sol_q    <= (pix_q == '0);
              sof_q    <= (pix_q == '0) && (line_q == '0);
            end
            // A load on the wrap edge is staged, never applied at that edge
            if (cfg_load) begin
              shad_q  <= cfg_in;
              state_q <= PEND;
              pend_q  <= 1'b1;
            end else if (frame_wrap && (state_q == PEND)) begin
              work_q  <= shad_q;
              state_q <= RUN;
              pend_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign sol          = sol_q;
  assign sof          = sof_q;
  assign pix_counter  = pix_q;
  assign line_counter = line_q;
  assign cfg_pending  = pend_q;
  assign running      = run_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timer_pg.sv
`default_nettype none
// ============================================================================
// Module   : tb_video_timer_pg
// Purpose  : Directed, table-driven bench for video_timer_pg with hand-written
//            sequences for deferred loads, restart, freeze and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_timer_pg;

  logic        clk = 1'b0;
  logic        reset_b, enable, reset_timer, cfg_load;
  logic [11:0] cfg_ticks_per_line, cfg_hs_start, cfg_hs_stop;
  logic [11:0] cfg_vs_pix_start, cfg_vs_pix_stop, cfg_de_pix_start, cfg_de_pix_stop;
  logic [9:0]  cfg_lines_per_frame, cfg_vs_line_start, cfg_vs_line_stop;
  logic [9:0]  cfg_de_line_start, cfg_de_line_stop, cfg_starting_line;
  logic        cfg_active_high;
  logic        hsync, vsync, de, sol, sof, cfg_pending, running;
  logic [11:0] pix_counter;
  logic [9:0]  line_counter;

  video_timer_pg #(.PIX_W(12), .LINE_W(10)) dut (
    .clk(clk), .reset_b(reset_b), .enable(enable), .reset_timer(reset_timer),
    .cfg_load(cfg_load), .cfg_ticks_per_line(cfg_ticks_per_line),
    .cfg_lines_per_frame(cfg_lines_per_frame), .cfg_hs_start(cfg_hs_start),
    .cfg_hs_stop(cfg_hs_stop), .cfg_vs_pix_start(cfg_vs_pix_start),
    .cfg_vs_pix_stop(cfg_vs_pix_stop), .cfg_vs_line_start(cfg_vs_line_start),
    .cfg_vs_line_stop(cfg_vs_line_stop), .cfg_de_pix_start(cfg_de_pix_start),
    .cfg_de_pix_stop(cfg_de_pix_stop), .cfg_de_line_start(cfg_de_line_start),
    .cfg_de_line_stop(cfg_de_line_stop), .cfg_starting_line(cfg_starting_line),
    .cfg_active_high(cfg_active_high), .hsync(hsync), .vsync(vsync), .de(de),
    .sol(sol), .sof(sof), .pix_counter(pix_counter), .line_counter(line_counter),
    .cfg_pending(cfg_pending), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct {
    int k;      // cycles since the first configuration load
    int ld;     // config id to load on the following edge (0 = none)
    int pix, line;
    int hs, vs, de, sol, sof, pend;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   k      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    cfg_load    = 1'b0;
    reset_timer = 1'b0;
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  // 1: base mode, 2: 6-cycle lines, 3: wrapping active-low hsync, 4: start line 2
  task automatic set_cfg(input int id);
    cfg_ticks_per_line  = 12'd9;  cfg_lines_per_frame = 10'd4;
    cfg_hs_start        = 12'd2;  cfg_hs_stop         = 12'd5;
    cfg_vs_pix_start    = 12'd4;  cfg_vs_line_start   = 10'd3;
    cfg_vs_pix_stop     = 12'd1;  cfg_vs_line_stop    = 10'd0;
    cfg_de_pix_start    = 12'd3;  cfg_de_pix_stop     = 12'd8;
    cfg_de_line_start   = 10'd1;  cfg_de_line_stop    = 10'd3;
    cfg_starting_line   = 10'd0;  cfg_active_high     = 1'b1;
    case (id)
      2: begin cfg_ticks_per_line = 12'd5; cfg_hs_start = 12'd1; cfg_hs_stop = 12'd3; end
      3: begin cfg_hs_start = 12'd8; cfg_hs_stop = 12'd2; cfg_active_high = 1'b0; end
      4: cfg_starting_line = 10'd2;
      default: ;
    endcase
  endtask

  task automatic check_vec(input vec_t v);
    chk($sformatf("k%0d pix", v.k),  int'(pix_counter),  v.pix);
    chk($sformatf("k%0d line", v.k), int'(line_counter), v.line);
    chk($sformatf("k%0d hsync", v.k), int'(hsync), v.hs);
    chk($sformatf("k%0d vsync", v.k), int'(vsync), v.vs);
    chk($sformatf("k%0d de", v.k),    int'(de),    v.de);
    chk($sformatf("k%0d sol", v.k),   int'(sol),   v.sol);
    chk($sformatf("k%0d sof", v.k),   int'(sof),   v.sof);
    chk($sformatf("k%0d pend", v.k),  int'(cfg_pending), v.pend);
    chk($sformatf("k%0d run", v.k),   int'(running), 1);
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      run_to(vecs[i].k);
      check_vec(vecs[i]);
      if (vecs[i].ld != 0) begin
        set_cfg(vecs[i].ld);
        cfg_load = 1'b1;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //            k  ld pix ln hs vs de sol sof pend
    vecs.push_back('{  0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{  1, 0, 1, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{  2, 0, 2, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{  3, 0, 3, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{  5, 0, 5, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{  6, 0, 6, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{ 11, 0, 1, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{ 14, 0, 4, 1, 1, 0, 1, 0, 0, 0});
    vecs.push_back('{ 18, 0, 8, 1, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{ 19, 0, 9, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{ 34, 0, 4, 3, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{ 35, 0, 5, 3, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{ 50, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{ 51, 0, 1, 0, 0, 1, 0, 1, 1, 0});
    vecs.push_back('{ 52, 0, 2, 0, 0, 0, 0, 0, 0, 0});   // index 14
    vecs.push_back('{212, 2, 2, 1, 0, 0, 0, 0, 0, 0});   // index 15
    vecs.push_back('{213, 0, 3, 1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{249, 0, 9, 4, 0, 1, 0, 0, 0, 1});
    vecs.push_back('{250, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{251, 0, 1, 0, 0, 1, 0, 1, 1, 0});
    vecs.push_back('{252, 0, 2, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{255, 0, 5, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{256, 0, 0, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{257, 0, 1, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{260, 3, 4, 1, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{261, 0, 5, 1, 0, 0, 1, 0, 0, 1});
    vecs.push_back('{279, 0, 5, 4, 0, 1, 0, 0, 0, 1});
    vecs.push_back('{280, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{281, 0, 1, 0, 0, 0, 0, 1, 1, 0});
    vecs.push_back('{282, 0, 2, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{283, 0, 3, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{288, 0, 8, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{289, 0, 9, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{290, 0, 0, 1, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{291, 0, 1, 1, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{293, 0, 3, 1, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{294, 0, 4, 1, 1, 1, 1, 0, 0, 0});   // index 36

    reset_b = 1'b0; enable = 1'b1; reset_timer = 1'b0; cfg_load = 1'b0;
    set_cfg(1);
    step(); step();
    chk("rst pix", int'(pix_counter), 0);
    chk("rst line", int'(line_counter), 0);
    chk("rst syncs", int'({hsync, vsync, de, sol, sof}), 0);
    chk("rst run", int'(running), 0);
    reset_b = 1'b1;
    step();
    chk("uncfg pix", int'(pix_counter), 0);
    chk("uncfg run", int'(running), 0);

    // Base mode from UNCFG takes effect on the next edge
    cfg_load = 1'b1;
    step();
    k = 0;
    apply_vecs(0, 14);

    cnt = 0;
    repeat (10) begin step(); cnt += int'(hsync); end
    chk("hsync width", cnt, 3);
    cnt = 0;
    repeat (50) begin step(); cnt += int'(vsync); end
    chk("vsync width", cnt, 17);
    cnt = 0;
    repeat (100) begin step(); cnt += int'(sof); end
    chk("sof per 100", cnt, 2);

    apply_vecs(15, 36);

    // Load exactly on the wrap edge: staged, old mode keeps running
    run_to(329);
    chk("wrap pix", int'(pix_counter), 9);
    chk("wrap line", int'(line_counter), 4);
    set_cfg(4);
    cfg_load = 1'b1;
    step();
    chk("wrapld pend", int'(cfg_pending), 1);
    chk("wrapld pix", int'(pix_counter), 0);
    run_to(336);
    chk("wrapld old hsync", int'(hsync), 1);

    // Restart while pending applies the shadow at once
    run_to(340);
    chk("pre-rt pend", int'(cfg_pending), 1);
    reset_timer = 1'b1;
    step();
    chk("rt pix", int'(pix_counter), 0);
    chk("rt line", int'(line_counter), 2);
    chk("rt pend", int'(cfg_pending), 0);
    chk("rt run", int'(running), 1);
    step();
    chk("rt+1 pix", int'(pix_counter), 1);
    chk("rt+1 sol", int'(sol), 1);
    chk("rt+1 sof", int'(sof), 0);
    run_to(347);
    chk("new hsync", int'(hsync), 0);
    chk("new de", int'(de), 1);

    // Freeze for 7 cycles mid-line
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("frz%0d pix", i), int'(pix_counter), 6);
      chk($sformatf("frz%0d line", i), int'(line_counter), 2);
      chk($sformatf("frz%0d de", i), int'(de), 1);
      chk($sformatf("frz%0d hsync", i), int'(hsync), 0);
    end
    enable = 1'b1;
    step();
    chk("thaw pix", int'(pix_counter), 7);
    step(); step();
    chk("thaw2 pix", int'(pix_counter), 9);
    chk("thaw2 de", int'(de), 0);

    // Asynchronous reset mid-frame
    #3 reset_b = 1'b0;
    #1;
    chk("arst pix", int'(pix_counter), 0);
    chk("arst line", int'(line_counter), 0);
    chk("arst outs", int'({hsync, vsync, de, sol, sof, cfg_pending}), 0);
    chk("arst run", int'(running), 0);
    step();
    reset_b = 1'b1;
    reset_timer = 1'b1;
    step();
    step(); step();
    chk("idle run", int'(running), 0);
    chk("idle pix", int'(pix_counter), 0);
    chk("idle hsync", int'(hsync), 0);
    set_cfg(1);
    cfg_load = 1'b1;
    step();
    chk("reload run", int'(running), 1);
    chk("reload pend", int'(cfg_pending), 0);
    step();
    chk("reload pix", int'(pix_counter), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
